// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel-timing source for the VGA display path.
//
// Divides the system clock down to a pixel enable, walks the HCount/VCount
// raster (default 800x525 for 640x480 @ 60 Hz from 50 MHz), decodes the
// active-low sync windows, and registers hsync, vsync and the blanked
// colour together so the three leave the block aligned.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high
//   rgb_in       colour for the current HCount/VCount from the drawing logic
//   HCount       horizontal pixel counter, 0..H_TOTAL-1
//   VCount       vertical line counter, 0..V_TOTAL-1
//   pixel_tick   one-clk pixel enable, once per CLK_DIV clks
//   video_on     counters are inside the visible area (combinational)
//   frame_start  one-clk pulse on the first clk the counters read (0,0)
//   hsync        active-low, registered
//   vsync        active-low, registered
//   rgb_out      registered, blanked colour
module vga_sync_gen #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] rgb_in,
  output logic [9:0] HCount,
  output logic [9:0] VCount,
  output logic       pixel_tick,
  output logic       video_on,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb_out
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

  // With CLK_DIV=1 the divider collapses to a single bit stuck at 0, so
  // pixel_tick is permanently high.
  localparam int unsigned      DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic             hs_window;
  logic             vs_window;

  always_comb begin
    pixel_tick = (div == DIV_MAX);
    video_on   = (HCount < H_VIS) && (VCount < V_VIS);
    hs_window  = (HCount >= HS_START) && (HCount <= HS_END);
    vs_window  = (VCount >= VS_START) && (VCount <= VS_END);
  end

  // Output stage samples the pre-edge counters, so hsync/vsync/rgb_out
  // trail HCount/VCount by exactly one pixel period.
  always_ff @(posedge clk) begin
    if (reset) begin
      div         <= '0;
      HCount      <= '0;
      VCount      <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      rgb_out     <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      div         <= pixel_tick ? '0 : div + 1'b1;
      if (pixel_tick) begin
        hsync   <= ~hs_window;
        vsync   <= ~vs_window;
        rgb_out <= video_on ? rgb_in : 3'b000;
        if (HCount == H_MAX) begin
          HCount <= '0;
          if (VCount == V_MAX) begin
            VCount      <= '0;
            frame_start <= 1'b1;
          end else begin
            VCount <= VCount + 10'd1;
          end
        end else begin
          HCount <= HCount + 10'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed bench for vga_sync_gen.
//   dut_a: default timing, CLK_DIV=2 (line-level checks, mid-line reset)
//   dut_b: reduced raster 15x8, CLK_DIV=1 (frame wrap, vsync, mid-frame reset)
//   dut_c: default timing, CLK_DIV=1 (one line in 800 clks)
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [2:0] rgb_a, rgb_b, rgb_c;

  logic [9:0] hc_a, vc_a, hc_b, vc_b, hc_c, vc_c;
  logic       tick_a, von_a, fs_a, hs_a, vs_a;
  logic       tick_b, von_b, fs_b, hs_b, vs_b;
  logic       tick_c, von_c, fs_c, hs_c, vs_c;
  logic [2:0] rgbo_a, rgbo_b, rgbo_c;

  int checks = 0;
  int errors = 0;

  vga_sync_gen #(.CLK_DIV(2)) dut_a (
    .clk(clk), .reset(rst_a), .rgb_in(rgb_a),
    .HCount(hc_a), .VCount(vc_a), .pixel_tick(tick_a), .video_on(von_a),
    .frame_start(fs_a), .hsync(hs_a), .vsync(vs_a), .rgb_out(rgbo_a)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_DISPLAY(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_DISPLAY(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_b (
    .clk(clk), .reset(rst_b), .rgb_in(rgb_b),
    .HCount(hc_b), .VCount(vc_b), .pixel_tick(tick_b), .video_on(von_b),
    .frame_start(fs_b), .hsync(hs_b), .vsync(vs_b), .rgb_out(rgbo_b)
  );

  vga_sync_gen #(.CLK_DIV(1)) dut_c (
    .clk(clk), .reset(rst_b), .rgb_in(rgb_c),
    .HCount(hc_c), .VCount(vc_c), .pixel_tick(tick_c), .video_on(von_c),
    .frame_start(fs_c), .hsync(hs_c), .vsync(vs_c), .rgb_out(rgbo_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Colour for pixel index p; never 000 so blanking is observable.
  function automatic logic [2:0] col(input int p);
    return 3'((p % 7) + 1);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int low_clks;
    int vlow_clks;
    int n;

    rst_a = 1'b1;
    rst_b = 1'b1;
    rgb_a = 3'b000;
    rgb_b = 3'b000;
    rgb_c = 3'b111;
    repeat (3) @(negedge clk);

    check("a_rst_hcount", 32'(hc_a), 0);
    check("a_rst_vcount", 32'(vc_a), 0);
    check("a_rst_hsync",  32'(hs_a), 1);
    check("a_rst_vsync",  32'(vs_a), 1);
    check("a_rst_rgb",    32'(rgbo_a), 0);
    check("a_rst_fs",     32'(fs_a), 0);
    check("a_rst_tick",   32'(tick_a), 0);

    // ---------------- dut_a: two full lines, CLK_DIV=2 ----------------
    rst_a = 1'b0;
    low_clks = 0;
    for (int k = 0; k <= 3203; k++) begin
      int p, src, sh;
      p = k / 2;
      check("a_tick",     32'(tick_a), 32'(k % 2));
      check("a_hcount",   32'(hc_a), 32'(p % 800));
      check("a_vcount",   32'(vc_a), 32'(p / 800));
      check("a_video_on", 32'(von_a), 32'((p % 800) < 640));
      check("a_vsync",    32'(vs_a), 1);
      check("a_fs",       32'(fs_a), 0);
      if (k < 2) begin
        check("a_hsync_init", 32'(hs_a), 1);
        check("a_rgb_init",   32'(rgbo_a), 0);
      end else begin
        src = k / 2 - 1;
        sh  = src % 800;
        check("a_hsync", 32'(hs_a), 32'(!(sh >= 656 && sh <= 751)));
        check("a_rgb",   32'(rgbo_a), (sh < 640) ? 32'(col(src)) : 0);
        if (sh == 639) check("a_rgb_px639", 32'(rgbo_a), 32'(col(src)));
        if (sh == 640) check("a_rgb_px640", 32'(rgbo_a), 0);
        if (k < 1602 && hs_a == 1'b0) low_clks++;
      end
      // Valid colour only on the clk whose edge is a tick; garbage otherwise.
      rgb_a = (k % 2 == 1) ? col(p) : ~col(p);
      @(negedge clk);
    end
    check("a_hsync_low_clks", 32'(low_clks), 192);

    // Mid-line reset at HCount=700 (inside the hsync window's output).
    n = 0;
    while (hc_a != 10'd700 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("a_reach_700", 32'(hc_a), 700);
    check("a_hsync_pre_rst", 32'(hs_a), 0);
    rst_a = 1'b1;
    @(negedge clk);
    check("a_mrst_hcount", 32'(hc_a), 0);
    check("a_mrst_vcount", 32'(vc_a), 0);
    check("a_mrst_hsync",  32'(hs_a), 1);
    check("a_mrst_rgb",    32'(rgbo_a), 0);
    check("a_mrst_tick",   32'(tick_a), 0);
    repeat (2) @(negedge clk);
    check("a_mrst_hold_hcount", 32'(hc_a), 0);
    rst_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("a_rel_tick",   32'(tick_a), 32'(k % 2));
      check("a_rel_hcount", 32'(hc_a), 32'(k / 2));
      @(negedge clk);
    end

    // ---------------- dut_b / dut_c: CLK_DIV=1 ----------------
    check("b_rst_hsync", 32'(hs_b), 1);
    check("b_rst_vsync", 32'(vs_b), 1);
    check("b_rst_fs",    32'(fs_b), 0);
    rst_b = 1'b0;
    low_clks  = 0;
    vlow_clks = 0;
    for (int k = 0; k <= 802; k++) begin
      int src, sh, sv;
      // Reduced raster: H_TOTAL=15 (hsync 10..12), V_TOTAL=8 (vsync 5..6).
      check("b_tick",   32'(tick_b), 1);
      check("b_hcount", 32'(hc_b), 32'(k % 15));
      check("b_vcount", 32'(vc_b), 32'((k / 15) % 8));
      check("b_fs",     32'(fs_b), 32'(k > 0 && k % 120 == 0));
      if (k == 0) begin
        check("b_hsync_init", 32'(hs_b), 1);
        check("b_vsync_init", 32'(vs_b), 1);
        check("b_rgb_init",   32'(rgbo_b), 0);
      end else begin
        src = k - 1;
        sh  = src % 15;
        sv  = (src / 15) % 8;
        check("b_hsync", 32'(hs_b), 32'(!(sh >= 10 && sh <= 12)));
        check("b_vsync", 32'(vs_b), 32'(!(sv >= 5 && sv <= 6)));
        check("b_rgb",   32'(rgbo_b), (sh < 8 && sv < 4) ? 32'(col(src)) : 0);
        if (sv == 4) check("b_rgb_row_vdisplay", 32'(rgbo_b), 0);
        if (k <= 120 && vs_b == 1'b0) vlow_clks++;
      end
      if (k <= 801) begin
        check("c_tick",   32'(tick_c), 1);
        check("c_hcount", 32'(hc_c), 32'(k % 800));
        check("c_vcount", 32'(vc_c), 32'(k / 800));
        if (k >= 1) begin
          sh = (k - 1) % 800;
          check("c_hsync", 32'(hs_c), 32'(!(sh >= 656 && sh <= 751)));
          check("c_rgb",   32'(rgbo_c), (sh < 640) ? 7 : 0);
          if (k <= 800 && hs_c == 1'b0) low_clks++;
        end
      end
      rgb_b = col(k);
      @(negedge clk);
    end
    check("b_vsync_low_clks", 32'(vlow_clks), 30);
    check("c_hsync_low_clks", 32'(low_clks), 96);

    // Mid-frame reset on dut_b with both syncs low at the outputs.
    n = 0;
    while (!(vc_b == 10'd5 && hc_b == 10'd11) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b_reach_5_11", 32'({vc_b, hc_b}), 32'({10'd5, 10'd11}));
    check("b_syncs_pre_rst", 32'({hs_b, vs_b}), 0);
    rst_b = 1'b1;
    @(negedge clk);
    check("b_mrst_hcount", 32'(hc_b), 0);
    check("b_mrst_vcount", 32'(vc_b), 0);
    check("b_mrst_hsync",  32'(hs_b), 1);
    check("b_mrst_vsync",  32'(vs_b), 1);
    check("b_mrst_rgb",    32'(rgbo_b), 0);
    check("b_mrst_fs",     32'(fs_b), 0);
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    check("b_rel_hcount", 32'(hc_b), 1);
    check("b_rel_fs",     32'(fs_b), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
